// File: rtl/gpio_debounce.sv
// gpio_debounce: synchronise raw pins, debounce each bit on a prescaled tick, strobe on change
module gpio_debounce #(
  parameter int WIDTH = 32,
  parameter int PRESCALE = 1000,
  parameter int STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] change_pulse,
  output logic             tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = STABLE_TICKS > 1 ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
  logic [WIDTH-1:0] sync1, sync2, accept;
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      pcnt <= '0;
      tick <= 1'b0;
      debounced_out <= RESET_VAL;
      change_pulse <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
      pcnt <= pcnt == P_LAST ? '0 : pcnt + 1'b1;
      tick <= pcnt == P_LAST;
      debounced_out <= debounced_out ^ accept;
      change_pulse <= accept;
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    assign accept[i] = tick && sync2[i] != debounced_out[i] && cnt == C_LAST;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (tick) cnt <= (sync2[i] == debounced_out[i] || accept[i]) ? '0 : cnt + 1'b1;
  end
endmodule
